io_write_port_bank: RTL
=======================

// Module: io_write_port_bank
// PURPOSE
//  Producer end of the I/O Empty/Full protocol for write ports: PORT_COUNT
//  small FIFOs that absorb CPU stores to I/O addresses and drain to external
//  consumers via valid/ready.
//  Drives the per-port Full bits (port_EF) that the write-side I/O check
//  selects and masks to predicate stores. A Full bit of 0 means ready to
//  accept a store.
// PARAMETERS
//  WORD_WIDTH       36  data word width
//  ADDR_WIDTH       10  CPU write address width
//  PORT_COUNT       8   number of write ports
//  PORT_BASE_ADDR   0   address of port 0; ports are contiguous
//  PORT_ADDR_WIDTH  3   port index width, clog2(PORT_COUNT)
//  DEPTH            2   entries per port FIFO; power of 2, >=2
// PORTS
//  clock      in   1                      single clock, rising edge
//  reset_n    in   1                      asynchronous, active-low reset
//  wren       in   1                      CPU store strobe
//  addr       in   ADDR_WIDTH             CPU store address
//  data       in   WORD_WIDTH             CPU store data
//  port_EF    out  PORT_COUNT             registered Full bit per port (1 = full)
//  out_data   out  PORT_COUNT*WORD_WIDTH  head word per port; port i in bits [i*W +: W]
//  out_valid  out  PORT_COUNT             head word valid per port
//  out_ready  in   PORT_COUNT             consumer accepts head word
//  overflow   out  PORT_COUNT             sticky: a store hit a full port
// BEHAVIOUR
//  - Reset (async assert, sync deassert handled upstream): all counts 0,
//    port_EF=0, out_valid=0, overflow=0, out_data=0. FIFO contents are
//    discarded, including in-flight words.
//  - Decode: hit = wren && BASE <= addr <= BASE+PORT_COUNT-1.
//    idx = (addr-BASE)[PORT_ADDR_WIDTH-1:0]. A store with no hit is ignored.
//  - push[i] = hit && idx==i. pop[i] = out_valid[i] && out_ready[i].
//  - Accept: a push is accepted if count<DEPTH, or if count==DEPTH and
//    pop[i] in the same cycle (pass-through at full).
//  - Reject: a rejected push drops the word and sets overflow[i] until reset.
//  - Count update: count' = count + accepted push - pop. Width is
//    clog2(DEPTH)+1. count never exceeds DEPTH or goes below 0.
//  - Head/tail pointers: clog2(DEPTH) bits, wrap naturally.
//  - out_valid[i] is registered, = (count'!=0).
//  - out_data[i] shows the head entry from registered storage. There is no
//    combinational path from data to out_data.
//  - Store latency: a store accepted at edge N is visible at out_data/out_valid
//    after edge N (cycle N+1) when the FIFO was empty.
//  - port_EF[i] is registered, = (count'==DEPTH). It updates on the edge
//    after the push or pop that changes it.
//  - Simultaneous push+pop: count unchanged, order preserved, EF unchanged.
//  - Empty + pop: impossible, because out_valid=0 gates pop.
//  - Full + push without pop: rejected, overflow set, state unchanged.
//  - out_ready toggling while out_valid=0 has no effect.
// STRUCTURE
//  - Shared defines header: EF encodings (WRITE_READY=0, READ_READY=1), so
//    the check logic and this block agree; port address-map localparams.
//  - Sub-module io_write_port_fifo (WORD_WIDTH, DEPTH): one register-array
//    FIFO, with push/pop/count/full/valid/head. Instantiated PORT_COUNT times
//    in a generate loop.
//  - Top level holds the address decode, the push demux, and the overflow
//    flags only.
// TESTING
//  - Reset, then idle -> port_EF=0, out_valid=0, overflow=0. Assert reset_n=0
//    with 2 words queued -> all outputs 0 immediately, before any clock edge.
//  - Store 0xA5 to BASE+3, out_ready=0 -> out_valid[3]=1 and out_data[3]=0xA5
//    on the next cycle; other ports are unaffected.
//  - 2 stores to port 1 (DEPTH=2), ready=0 -> port_EF[1]=1 after the 2nd edge.
//    A 3rd store is dropped and overflow[1]=1. Drain gives words 1 and 2 in
//    order.
//  - Port 5 full, store and out_ready[5]=1 in the same cycle -> push accepted,
//    overflow[5]=0, EF stays 1, FIFO order preserved.
//  - Store to BASE+PORT_COUNT, and to BASE-1 -> no port changes state, no
//    overflow.
//  - Random stores and ready over 10k cycles vs a scoreboard per port -> no
//    loss, no reorder, and EF==(count==DEPTH) every cycle.

Source files
------------

// File: rtl/io_write_port_bank_pkg.sv
// Shared definitions for the I/O write-port bank: Empty/Full encodings that the
// write-side I/O check agrees on, and the default port address map.
package io_write_port_bank_pkg;

  localparam int DEF_WORD_WIDTH      = 36;
  localparam int DEF_ADDR_WIDTH      = 10;
  localparam int DEF_PORT_COUNT      = 8;
  localparam int DEF_PORT_BASE_ADDR  = 0;
  localparam int DEF_PORT_ADDR_WIDTH = 3;
  localparam int DEF_DEPTH           = 2;

  // A write port reports WRITE_READY (0) while it can take a store.
  typedef enum logic {
    WRITE_READY = 1'b0,
    READ_READY  = 1'b1
  } ef_t;

endpackage

// File: rtl/io_write_port_fifo.sv
// One write-port FIFO: register-array storage, registered valid/full flags,
// and pass-through acceptance when full and draining in the same cycle.
module io_write_port_fifo #(
  parameter int WORD_WIDTH = 36,
  parameter int DEPTH      = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic                  ready,
  output logic                  accepted,
  output logic                  valid,
  output logic                  full,
  output logic [WORD_WIDTH-1:0] head
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  head_ptr;
  logic [PTR_WIDTH-1:0]  tail_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  count_next;
  logic                  pop;

  assign pop        = valid && ready;
  assign accepted   = push && ((count != FULL_COUNT) || pop);
  assign count_next = count + CNT_WIDTH'(accepted) - CNT_WIDTH'(pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      valid    <= 1'b0;
      full     <= 1'b0;
    end else begin
      if (accepted) tail_ptr <= tail_ptr + PTR_WIDTH'(1);
      if (pop)      head_ptr <= head_ptr + PTR_WIDTH'(1);
      count <= count_next;
      valid <= (count_next != '0);
      full  <= (count_next == FULL_COUNT);
    end
  end

  // NOTE: storage has no reset; a cleared count makes stale words unreachable,
  // and the head output is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (accepted) mem[tail_ptr] <= data;
  end

  assign head = valid ? mem[head_ptr] : '0;

endmodule

// File: rtl/io_write_port_bank.sv
// Write-port bank: decodes CPU stores onto PORT_COUNT FIFOs, publishes their
// Full bits for store predication, and records sticky overflow per port.
module io_write_port_bank
  import io_write_port_bank_pkg::*;
#(
  parameter int WORD_WIDTH      = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int PORT_COUNT      = DEF_PORT_COUNT,
  parameter int PORT_BASE_ADDR  = DEF_PORT_BASE_ADDR,
  parameter int PORT_ADDR_WIDTH = DEF_PORT_ADDR_WIDTH,
  parameter int DEPTH           = DEF_DEPTH
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             wren,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [WORD_WIDTH-1:0]            data,
  output logic [PORT_COUNT-1:0]            port_EF,
  output logic [PORT_COUNT*WORD_WIDTH-1:0] out_data,
  output logic [PORT_COUNT-1:0]            out_valid,
  input  logic [PORT_COUNT-1:0]            out_ready,
  output logic [PORT_COUNT-1:0]            overflow
);

  logic [ADDR_WIDTH:0]          offset;
  logic                         hit;
  logic [PORT_ADDR_WIDTH-1:0]   idx;
  logic [PORT_COUNT-1:0]        push;
  logic [PORT_COUNT-1:0]        accepted;

  // The extra top bit is the borrow: set when addr lies below the base.
  assign offset = {1'b0, addr} - (ADDR_WIDTH+1)'(PORT_BASE_ADDR);
  assign hit    = wren && !offset[ADDR_WIDTH]
                  && (offset[ADDR_WIDTH-1:0] < ADDR_WIDTH'(PORT_COUNT));
  assign idx    = offset[PORT_ADDR_WIDTH-1:0];

  // NOTE: push gets a default before the conditional write, so no latch.
  always_comb begin
    push = '0;
    if (hit) push[idx] = 1'b1;
  end

  for (genvar i = 0; i < PORT_COUNT; i++) begin : g_port
    logic full;

    io_write_port_fifo #(
      .WORD_WIDTH (WORD_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clock    (clock),
      .reset_n  (reset_n),
      .push     (push[i]),
      .data     (data),
      .ready    (out_ready[i]),
      .accepted (accepted[i]),
      .valid    (out_valid[i]),
      .full     (full),
      .head     (out_data[i*WORD_WIDTH +: WORD_WIDTH])
    );

    assign port_EF[i] = full ? READ_READY : WRITE_READY;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow <= '0;
    else          overflow <= overflow | (push & ~accepted);
  end

endmodule
